// File: rtl/contador_bcd_mux.sv
// Four-digit BCD up/down counter with a built-in scanner for a multiplexed display.
// The scanner emits one BCD digit at a time with an active-low common-anode select.
module contador_bcd_mux #(
    parameter int DIV_CONTEO  = 50000000,
    parameter int DIV_BARRIDO = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        habilitar,
    input  logic        arriba,
    input  logic        cargar,
    input  logic [15:0] valor_carga,
    output logic [15:0] cuenta,
    output logic [3:0]  display,
    output logic [3:0]  anodo,
    output logic        acarreo
);
    localparam int PW = (DIV_CONTEO  > 1) ? $clog2(DIV_CONTEO)  : 1;
    localparam int SW = (DIV_BARRIDO > 1) ? $clog2(DIV_BARRIDO) : 1;

    logic [PW-1:0] presc_r;
    logic [SW-1:0] scan_r;
    logic [1:0]    idx_r;
    logic [15:0]   cuenta_r;
    logic          acarreo_r;
    logic          tick_s;
    logic [16:0]   step_s;

    // One BCD step over all four digits; bit 16 is set when the count wraps.
    function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        c;
        logic [3:0]  d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return {c, r};
    endfunction

    // Non-BCD load digits are forced to zero so cuenta always holds valid BCD.
    function automatic logic [15:0] bcd_sanitize(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd0 : v[4*i +: 4];
        end
        return r;
    endfunction

    assign tick_s = habilitar && (presc_r == PW'(DIV_CONTEO - 1));
    assign step_s = bcd_step(cuenta_r, arriba);

    // Prescaler: free-runs while enabled, restarts on tick or load.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
        end else if (cargar || tick_s) begin
            presc_r <= '0;
        end else if (habilitar) begin
            presc_r <= presc_r + PW'(1);
        end else begin
            presc_r <= presc_r;
        end
    end

    // Count register and wrap pulse; a load discards a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta_r  <= 16'h0000;
            acarreo_r <= 1'b0;
        end else if (cargar) begin
            cuenta_r  <= bcd_sanitize(valor_carga);
            acarreo_r <= 1'b0;
        end else if (tick_s) begin
            cuenta_r  <= step_s[15:0];
            acarreo_r <= step_s[16];
        end else begin
            cuenta_r  <= cuenta_r;
            acarreo_r <= 1'b0;
        end
    end

    // Digit scanner, independent of enable and load.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_r <= '0;
            idx_r  <= 2'd0;
        end else if (scan_r == SW'(DIV_BARRIDO - 1)) begin
            scan_r <= '0;
            idx_r  <= idx_r + 2'd1;
        end else begin
            scan_r <= scan_r + SW'(1);
            idx_r  <= idx_r;
        end
    end

    // Digit mux is combinational so a count change shows on the selected digit at once.
    always_comb begin
        anodo = ~(4'b0001 << idx_r);
        case (idx_r)
            2'd0:    display = cuenta_r[3:0];
            2'd1:    display = cuenta_r[7:4];
            2'd2:    display = cuenta_r[11:8];
            2'd3:    display = cuenta_r[15:12];
            default: display = cuenta_r[3:0];
        endcase
    end

    assign cuenta  = cuenta_r;
    assign acarreo = acarreo_r;
endmodule

// File: tb/tb_contador_bcd_mux.sv
// Bench for contador_bcd_mux: decimal-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_contador_bcd_mux;
    localparam int DC = 4;
    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        habilitar = 1'b0;
    logic        arriba = 1'b1;
    logic        cargar = 1'b0;
    logic [15:0] valor_carga = 16'h0000;
    logic [15:0] cuenta;
    logic [3:0]  display;
    logic [3:0]  anodo;
    logic        acarreo;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, in plain decimal terms
    int m_val   = 0;
    int m_presc = 0;
    int m_scan  = 0;
    int m_idx   = 0;
    bit m_carry = 1'b0;
    bit m_valid = 1'b0;

    int         pow10 [4] = '{1, 10, 100, 1000};
    logic [3:0] an_tab[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    contador_bcd_mux #(.DIV_CONTEO(DC), .DIV_BARRIDO(DB)) dut (
        .clk(clk), .rst(rst), .habilitar(habilitar), .arriba(arriba),
        .cargar(cargar), .valor_carga(valor_carga), .cuenta(cuenta),
        .display(display), .anodo(anodo), .acarreo(acarreo)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10[i]) % 10);
        return r;
    endfunction

    function automatic int load_dec(input logic [15:0] v);
        int s = 0;
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] <= 4'd9) s += int'(v[4*i +: 4]) * pow10[i];
        return s;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tick;
        if (rst) begin
            m_val = 0; m_presc = 0; m_scan = 0; m_idx = 0; m_carry = 1'b0; m_valid = 1'b1;
        end else begin
            tick = habilitar && (m_presc == DC - 1);
            if (m_scan == DB - 1) begin m_scan = 0; m_idx = (m_idx + 1) % 4; end
            else m_scan++;
            if (cargar) begin
                m_val = load_dec(valor_carga); m_presc = 0; m_carry = 1'b0;
            end else if (tick) begin
                m_presc = 0;
                if (arriba) begin m_carry = (m_val == 9999); m_val = (m_val + 1) % 10000; end
                else begin m_carry = (m_val == 0); m_val = (m_val + 9999) % 10000; end
            end else begin
                m_carry = 1'b0;
                if (habilitar) m_presc++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("model_cuenta", cuenta, to_bcd(m_val));
            chk("model_anodo", {12'h000, anodo}, {12'h000, an_tab[m_idx]});
            chk("model_display", {12'h000, display}, 16'((m_val / pow10[m_idx]) % 10));
            chk("model_acarreo", {15'h0000, acarreo}, {15'h0000, m_carry});
            n_checks++;
            if (display > 4'd9) begin
                n_fail++;
                $display("FAIL display_bcd: got %h, expected <= 9", display);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        bit found;
        // 1. reset and scan
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_cuenta", cuenta, 16'h0000);
        chk("rst_anodo", {12'h000, anodo}, 16'h000E);
        chk("rst_display", {12'h000, display}, 16'h0000);
        for (int k = 1; k <= 4; k++) begin
            repeat (2) @(negedge clk);
            chk("scan_anodo", {12'h000, anodo}, {12'h000, an_tab[k % 4]});
        end
        chk("scan_cuenta_hold", cuenta, 16'h0000);

        // 2. up count and ripple
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; habilitar = 1'b1; arriba = 1'b1;
        repeat (3) @(negedge clk);
        chk("up_before_tick", cuenta, 16'h0000);
        @(negedge clk);
        chk("up_first", cuenta, 16'h0001);
        cargar = 1'b1; valor_carga = 16'h0099;
        @(negedge clk);
        cargar = 1'b0;
        chk("load_0099", cuenta, 16'h0099);
        repeat (4) @(negedge clk);
        chk("ripple_0100", cuenta, 16'h0100);

        // 3. wrap both ways
        cargar = 1'b1; valor_carga = 16'h9999;
        @(negedge clk);
        cargar = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrap_up_pre_acarreo", {15'h0000, acarreo}, 16'h0000);
        @(negedge clk);
        chk("wrap_up_cuenta", cuenta, 16'h0000);
        chk("wrap_up_acarreo", {15'h0000, acarreo}, 16'h0001);
        arriba = 1'b0;
        @(negedge clk);
        chk("wrap_up_acarreo_end", {15'h0000, acarreo}, 16'h0000);
        repeat (3) @(negedge clk);
        chk("wrap_dn_cuenta", cuenta, 16'h9999);
        chk("wrap_dn_acarreo", {15'h0000, acarreo}, 16'h0001);
        @(negedge clk);
        chk("wrap_dn_acarreo_end", {15'h0000, acarreo}, 16'h0000);

        // 4. load priority over tick, digit sanitising
        arriba = 1'b1;
        repeat (2) @(negedge clk);
        cargar = 1'b1; valor_carga = 16'h12F4;
        @(negedge clk);
        cargar = 1'b0;
        chk("load_sanitize", cuenta, 16'h1204);
        repeat (3) @(negedge clk);
        chk("load_no_early_inc", cuenta, 16'h1204);
        @(negedge clk);
        chk("load_next_inc", cuenta, 16'h1205);

        // 5. enable hold at prescaler=2
        repeat (2) @(negedge clk);
        habilitar = 1'b0;
        repeat (10) @(negedge clk);
        chk("hold_cuenta", cuenta, 16'h1205);
        habilitar = 1'b1;
        @(negedge clk);
        chk("hold_resume_1", cuenta, 16'h1205);
        @(negedge clk);
        chk("hold_resume_2", cuenta, 16'h1206);

        // 6. reset mid-operation at index 2
        habilitar = 1'b0; cargar = 1'b1; valor_carga = 16'h0357;
        @(negedge clk);
        cargar = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 16 && !found; t++) begin
            if (anodo == 4'b1011) found = 1'b1;
            else @(negedge clk);
        end
        chk("mid_find_idx2", {15'h0000, found}, 16'h0001);
        chk("mid_display_3", {12'h000, display}, 16'h0003);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cuenta", cuenta, 16'h0000);
        chk("mid_rst_anodo", {12'h000, anodo}, 16'h000E);
        chk("mid_rst_display", {12'h000, display}, 16'h0000);
        chk("mid_rst_acarreo", {15'h0000, acarreo}, 16'h0000);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
